adc_sample_averager: RTL

//  Downstream consumer of the ADC conversion core. Takes each 10-bit conversion word plus its
//  one-cycle done strobe and averages 2^N consecutive samples (boxcar decimation).

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_sync_fifo.sv | 59 +++++
 rtl/adc_sample_averager.sv | 101 ++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared ADC datapath constants and types.
// Used by the conversion core and by its downstream consumers.
package adc_pkg;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned LOG2_MAX = 4;
    localparam int unsigned CFG_W    = 3;

    typedef logic [DATA_W-1:0]          sample_t;
    typedef logic [DATA_W+LOG2_MAX-1:0] acc_t;
    typedef logic [LOG2_MAX-1:0]        cnt_t;
    typedef logic [CFG_W-1:0]           nexp_t;

    localparam nexp_t LOG2_MAX_N = nexp_t'(LOG2_MAX);

    function automatic nexp_t clamp_log2(input nexp_t cfg);
        return (cfg > LOG2_MAX_N) ? LOG2_MAX_N : cfg;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with fill level.
// Head reads as zero while empty; a push into a full FIFO is taken only with a same-cycle pop.
module adc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [PTR_W-1:0] o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;

    logic [PTR_W-1:0] w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer bit separates full from empty when the indices match.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (w_level == '0);
    assign w_full    = (w_level == PTR_W'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[PTR_W-2:0]] <= i_data;
                r_wr_ptr                   <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-2:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_level = w_level;

endmodule

// File: rtl/adc_sample_averager.sv
// Boxcar decimator: averages 2^N consecutive ADC samples and queues results in a FWFT FIFO.
// Tracks FIFO fill level and a sticky flag for results dropped on a full queue.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              enable_i,
    input  logic [CFG_W-1:0]  cfg_log2_avg_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    output logic [DATA_W-1:0] avg_o,
    output logic              avg_valid_o,
    input  logic              avg_ready_i,
    output logic [LVL_W-1:0]  fifo_level_o,
    output logic              overflow_o,
    input  logic              overflow_clr_i
);

    acc_t  r_acc;
    cnt_t  r_cnt;
    nexp_t r_n_lat;
    logic  r_overflow;

    nexp_t             w_n_eff;
    logic [LOG2_MAX:0] w_win_m1;
    logic              w_last;
    acc_t              w_sum;
    sample_t           w_result;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;

    // The first sample of a window uses the live exponent; later ones use the latched copy.
    assign w_n_eff  = (r_cnt == '0) ? clamp_log2(cfg_log2_avg_i) : r_n_lat;
    assign w_win_m1 = ((LOG2_MAX + 1)'(1) << w_n_eff) - (LOG2_MAX + 1)'(1);
    assign w_last   = ({1'b0, r_cnt} == w_win_m1);
    assign w_sum    = r_acc + acc_t'(sample_i);
    assign w_result = sample_t'(w_sum >> w_n_eff);

    assign w_push = enable_i & sample_valid_i & w_last;
    assign w_pop  = ~w_empty & avg_ready_i;
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_n_lat <= '0;
        end else if (!enable_i) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (sample_valid_i) begin
            if (r_cnt == '0) begin
                r_n_lat <= w_n_eff;
            end
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clr_i) begin
            r_overflow <= 1'b0;
        end
    end

    adc_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_push  (w_push),
        .i_data  (w_result),
        .o_full  (w_full),
        .i_pop   (avg_ready_i),
        .o_data  (avg_o),
        .o_empty (w_empty),
        .o_level (fifo_level_o)
    );

    assign avg_valid_o = ~w_empty;
    assign overflow_o  = r_overflow;

endmodule
